// File: rtl/cordic_sincos_pkg.sv
// cordic_sincos shared definitions.
// Angle table, gain constant and FSM states.
package cordic_sincos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEG_90  = 90;
  localparam int DEG_180 = 180;

  // constants below are scaled by 2^18
  localparam longint K_Q18 = 64'sd159188;

  function automatic longint atan_q18(input logic [4:0] i);
    unique case (i)
      5'd0:  return 64'sd11796480;
      5'd1:  return 64'sd6963869;
      5'd2:  return 64'sd3679517;
      5'd3:  return 64'sd1867780;
      5'd4:  return 64'sd937515;
      5'd5:  return 64'sd469214;
      5'd6:  return 64'sd234664;
      5'd7:  return 64'sd117339;
      5'd8:  return 64'sd58671;
      5'd9:  return 64'sd29335;
      5'd10: return 64'sd14668;
      5'd11: return 64'sd7334;
      5'd12: return 64'sd3667;
      5'd13: return 64'sd1833;
      5'd14: return 64'sd917;
      5'd15: return 64'sd458;
      5'd16: return 64'sd229;
      5'd17: return 64'sd115;
      5'd18: return 64'sd57;
      5'd19: return 64'sd29;
      5'd20: return 64'sd14;
      5'd21: return 64'sd7;
      5'd22: return 64'sd4;
      5'd23: return 64'sd2;
      default: return 64'sd0;
    endcase
  endfunction

  // rescale a 2^18 constant to 2^s with rounding
  function automatic longint scale_q18(
    input longint v,
    input int     s
  );
    if (s >= 18) return v <<< (s - 18);
    return (v + (longint'(1) <<< (17 - s))) >>> (18 - s);
  endfunction

endpackage

// File: rtl/cordic_sincos_stage.sv
// cordic_sincos single micro-rotation.
// Purely combinational, reusable in a pipeline.
module cordic_stage
  import cordic_sincos_pkg::*;
#(
  parameter int IW = 36,
  parameter int S  = 18
) (
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  input  logic signed [IW-1:0] z,
  input  logic        [4:0]    i,
  output logic signed [IW-1:0] xn,
  output logic signed [IW-1:0] yn,
  output logic signed [IW-1:0] zn
);

  logic signed [IW-1:0] xs;
  logic signed [IW-1:0] ys;
  logic signed [IW-1:0] at;

  // rotate toward z = 0; z >= 0 counts as positive
  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    at = IW'(scale_q18(atan_q18(i), S));
    if (z[IW-1]) begin
      xn = x + ys;
      yn = y - xs;
      zn = z + at;
    end else begin
      xn = x - ys;
      yn = y + xs;
      zn = z - at;
    end
  end

endmodule

// File: rtl/cordic_sincos.sv
// cordic_sincos iterative sin/cos engine.
// Folds +-180 deg, then runs ITER rotations.
module cordic_sincos
  import cordic_sincos_pkg::*;
#(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int ITER  = 16,
  parameter int GUARD = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                ready,
  input  logic signed [W-1:0] xita,
  output logic                valid,
  output logic signed [W-1:0] cos,
  output logic signed [W-1:0] sin,
  output logic                err
);

  localparam int IW = W + GUARD + 2;
  localparam int S  = FRAC + GUARD;

  localparam logic signed [W-1:0] D90 =
    W'(longint'(DEG_90) <<< FRAC);
  localparam logic signed [W-1:0] D180 =
    W'(longint'(DEG_180) <<< FRAC);
  localparam logic signed [W-1:0] ND90  = -D90;
  localparam logic signed [W-1:0] ND180 = -D180;

  localparam logic signed [IW-1:0] D180_Z =
    IW'(longint'(DEG_180) <<< S);
  localparam logic signed [IW-1:0] K_INIT =
    IW'(scale_q18(K_Q18, S));
  localparam logic signed [IW-1:0] HALF =
    IW'(longint'(1) <<< (GUARD - 1));
  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  state_t               state;
  logic [4:0]           cnt;
  logic signed [W-1:0]  ang;
  logic signed [IW-1:0] x;
  logic signed [IW-1:0] y;
  logic signed [IW-1:0] z;
  logic                 neg;
  logic                 err_p;

  logic signed [IW-1:0] xn;
  logic signed [IW-1:0] yn;
  logic signed [IW-1:0] zn;
  logic signed [IW-1:0] ang_z;
  logic signed [IW-1:0] xr;
  logic signed [IW-1:0] yr;
  logic                 over;
  logic                 hi;
  logic                 lo;

  assign ang_z = IW'(ang) <<< GUARD;
  assign over  = (ang > D180) || (ang < ND180);
  assign hi    = !over && (ang > D90);
  assign lo    = !over && (ang < ND90);
  assign xr    = (x + HALF) >>> GUARD;
  assign yr    = (y + HALF) >>> GUARD;

  cordic_stage #(
    .IW (IW),
    .S  (S)
  ) u_stage (
    .x  (x),
    .y  (y),
    .z  (z),
    .i  (cnt),
    .xn (xn),
    .yn (yn),
    .zn (zn)
  );

  // request FSM with datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ang   <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      neg   <= 1'b0;
      err_p <= 1'b0;
      ready <= 1'b1;
      valid <= 1'b0;
      cos   <= '0;
      sin   <= '0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            ang   <= xita;
            ready <= 1'b0;
            state <= ST_FOLD;
          end
        end
        ST_FOLD: begin
          cnt   <= '0;
          x     <= K_INIT;
          y     <= '0;
          neg   <= 1'b0;
          err_p <= 1'b0;
          state <= ST_ITER;
          unique case (1'b1)
            over: begin
              err_p <= 1'b1;
              x     <= '0;
              z     <= '0;
              state <= ST_DONE;
            end
            hi: begin
              z   <= ang_z - D180_Z;
              neg <= 1'b1;
            end
            lo: begin
              z   <= ang_z + D180_Z;
              neg <= 1'b1;
            end
            default: z <= ang_z;
          endcase
        end
        ST_ITER: begin
          x   <= xn;
          y   <= yn;
          z   <= zn;
          cnt <= cnt + 5'd1;
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          cos   <= neg ? W'(-xr) : W'(xr);
          sin   <= neg ? W'(-yr) : W'(yr);
          err   <= err_p;
          cnt   <= '0;
          valid <= 1'b1;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos.
// Reference uses real-valued $cos/$sin.
module tb_cordic_sincos;

  localparam int W = 32;
  localparam int TOL = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] xita = '0;
  logic         ready;
  logic         valid;
  logic [W-1:0] cos_o;
  logic [W-1:0] sin_o;
  logic         err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_sincos #(
    .W     (32),
    .FRAC  (16),
    .ITER  (16),
    .GUARD (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ready (ready),
    .xita  (xita),
    .valid (valid),
    .cos   (cos_o),
    .sin   (sin_o),
    .err   (err)
  );

  function automatic void model(
    input  logic [W-1:0] a,
    output int           ec,
    output int           es,
    output logic         ee
  );
    real deg;
    real rad;
    deg = $itor($signed(a)) / 65536.0;
    if (deg > 180.0 || deg < -180.0) begin
      ee = 1'b1;
      ec = 0;
      es = 0;
    end else begin
      ee = 1'b0;
      rad = deg * 3.14159265358979 / 180.0;
      ec = int'($cos(rad) * 65536.0);
      es = int'($sin(rad) * 65536.0);
    end
  endfunction

  task automatic run_req(
    input  logic [W-1:0] a,
    output int           lat,
    output logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic         e
  );
    xita = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
    c = cos_o;
    s = sin_o;
    e = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", ready);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", valid);
    end
    checks++;
    if (cos_o !== 32'h0 || sin_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_data cos=%h sin=%h want 0", cos_o, sin_o);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b want=0", err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ang [7];
    logic [W-1:0] ec  [7];
    logic [W-1:0] es  [7];
    int lat;
    int d;
    logic [W-1:0] c;
    logic [W-1:0] s;
    logic e;
    ang[0] = 32'h0000_0000; ec[0] = 32'h0001_0000; es[0] = 32'h0;
    ang[1] = 32'h001E_0000; ec[1] = 32'h0000_DDB4; es[1] = 32'h0000_8000;
    ang[2] = 32'hFF6A_0000; ec[2] = 32'hFFFF_224C; es[2] = 32'hFFFF_8000;
    ang[3] = 32'h00B4_0000; ec[3] = 32'hFFFF_0000; es[3] = 32'h0;
    ang[4] = 32'hFF4C_0000; ec[4] = 32'hFFFF_0000; es[4] = 32'h0;
    ang[5] = 32'h005A_0000; ec[5] = 32'h0;         es[5] = 32'h0001_0000;
    ang[6] = 32'hFFA6_0000; ec[6] = 32'h0;         es[6] = 32'hFFFF_0000;
    for (int k = 0; k < 7; k++) begin
      run_req(ang[k], lat, c, s, e);
      checks++;
      if (lat != 18) begin
        failures++;
        $display("FAIL dir_lat ang=%h got=%0d want=18", ang[k], lat);
      end
      checks++;
      d = $signed(c) - $signed(ec[k]);
      if (d > TOL || d < -TOL) begin
        failures++;
        $display("FAIL dir_cos ang=%h got=%h want=%h+-4", ang[k], c, ec[k]);
      end
      checks++;
      d = $signed(s) - $signed(es[k]);
      if (d > TOL || d < -TOL) begin
        failures++;
        $display("FAIL dir_sin ang=%h got=%h want=%h+-4", ang[k], s, es[k]);
      end
      checks++;
      if (e !== 1'b0) begin
        failures++;
        $display("FAIL dir_err ang=%h got=%b want=0", ang[k], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int d;
    logic [W-1:0] c;
    logic [W-1:0] s;
    logic e;
    run_req(32'h002D_0000, lat, c, s, e);
    checks++;
    if (lat != 18) begin
      failures++;
      $display("FAIL b2b_lat45 got=%0d want=18", lat);
    end
    checks++;
    d = $signed(c) - 32'sh0000_B505;
    if (d > TOL || d < -TOL) begin
      failures++;
      $display("FAIL b2b_cos45 got=%h want=0000b505+-4", c);
    end
    checks++;
    d = $signed(s) - 32'sh0000_B505;
    if (d > TOL || d < -TOL) begin
      failures++;
      $display("FAIL b2b_sin45 got=%h want=0000b505+-4", s);
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_at_valid got=%b want=1", ready);
    end
    run_req(32'h003C_0000, lat, c, s, e);
    checks++;
    if (lat != 18) begin
      failures++;
      $display("FAIL b2b_lat60 got=%0d want=18", lat);
    end
    checks++;
    d = $signed(c) - 32'sh0000_8000;
    if (d > TOL || d < -TOL) begin
      failures++;
      $display("FAIL b2b_cos60 got=%h want=00008000+-4", c);
    end
    checks++;
    d = $signed(s) - 32'sh0000_DDB4;
    if (d > TOL || d < -TOL) begin
      failures++;
      $display("FAIL b2b_sin60 got=%h want=0000ddb4+-4", s);
    end
  endtask

  task automatic test_err();
    logic [W-1:0] ang [3];
    int lat;
    logic [W-1:0] c;
    logic [W-1:0] s;
    logic e;
    ang[0] = 32'h00C8_0000;
    ang[1] = 32'h00B4_0001;
    ang[2] = 32'hFF4B_FFFF;
    for (int k = 0; k < 3; k++) begin
      run_req(ang[k], lat, c, s, e);
      checks++;
      if (lat != 2) begin
        failures++;
        $display("FAIL err_lat ang=%h got=%0d want=2", ang[k], lat);
      end
      checks++;
      if (e !== 1'b1) begin
        failures++;
        $display("FAIL err_flag ang=%h got=%b want=1", ang[k], e);
      end
      checks++;
      if (c !== 32'h0 || s !== 32'h0) begin
        failures++;
        $display("FAIL err_data ang=%h cos=%h sin=%h want 0", ang[k], c, s);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_hold got=%b want=1", err);
    end
    run_req(32'h0, lat, c, s, e);
    checks++;
    if (e !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b want=0", e);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    int lat;
    int d;
    int ec;
    int es;
    logic ee;
    logic [W-1:0] c;
    logic [W-1:0] s;
    logic e;
    for (int k = 0; k < 40; k++) begin
      a = W'(int'($urandom_range(0, 26214400)) - 13107200);
      model(a, ec, es, ee);
      run_req(a, lat, c, s, e);
      checks++;
      if (lat != (ee ? 2 : 18)) begin
        failures++;
        $display("FAIL rnd_lat ang=%h got=%0d want=%0d",
                 a, lat, ee ? 2 : 18);
      end
      checks++;
      if (e !== ee) begin
        failures++;
        $display("FAIL rnd_err ang=%h got=%b want=%b", a, e, ee);
      end
      checks++;
      d = $signed(c) - ec;
      if (d > TOL || d < -TOL) begin
        failures++;
        $display("FAIL rnd_cos ang=%h got=%0d want=%0d+-4",
                 a, $signed(c), ec);
      end
      checks++;
      d = $signed(s) - es;
      if (d > TOL || d < -TOL) begin
        failures++;
        $display("FAIL rnd_sin ang=%h got=%0d want=%0d+-4",
                 a, $signed(s), es);
      end
    end
  endtask

  task automatic test_busy_start();
    int lat;
    int d;
    int extra;
    xita = 32'h001E_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 4) start = 1'b0;
      if (n == 3) begin
        checks++;
        if (ready !== 1'b0) begin
          failures++;
          $display("FAIL busy_ready got=%b want=0", ready);
        end
        xita = 32'h00C8_0000;
        start = 1'b1;
      end
      if (valid) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat != 18) begin
      failures++;
      $display("FAIL busy_lat got=%0d want=18", lat);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL busy_err got=%b want=0", err);
    end
    checks++;
    d = $signed(cos_o) - 32'sh0000_DDB4;
    if (d > TOL || d < -TOL) begin
      failures++;
      $display("FAIL busy_cos got=%h want=0000ddb4+-4", cos_o);
    end
    extra = 0;
    for (int n = 0; n < 24; n++) begin
      @(posedge clk); #1;
      if (valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL busy_queued got=%0d want=0 valids", extra);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [W-1:0] c;
    logic [W-1:0] s;
    logic e;
    run_req(32'h001E_0000, lat, c, s, e);
    xita = 32'h002D_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_busy got=%b want=0", ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_ctl ready=%b valid=%b err=%b want 1/0/0",
               ready, valid, err);
    end
    checks++;
    if (cos_o !== 32'h0 || sin_o !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst_data cos=%h sin=%h want 0", cos_o, sin_o);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    #3;
    rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_no_valid got=%0d want=0", seen);
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_ready_after got=%b want=1", ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_err();
    test_random();
    test_busy_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
